// File: rtl/alu_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_seq_pkg                                               |
// | Purpose  : Opcodes, FSM states and helpers for param_alu_seq.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package alu_seq_pkg;

    localparam int MAX_W = 16;

    localparam logic [2:0] OP_ADD      = 3'b000;
    localparam logic [2:0] OP_SUB      = 3'b001;
    localparam logic [2:0] OP_LOGIC    = 3'b010;
    localparam logic [2:0] OP_ORRED    = 3'b011;
    localparam logic [2:0] OP_POPMATCH = 3'b100;
    localparam logic [2:0] OP_CONCAT   = 3'b101;
    localparam logic [2:0] OP_HOLD     = 3'b110;
    localparam logic [2:0] OP_MUL      = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // Operands narrower than MAX_W are zero-extended by the caller.
    function automatic logic [4:0] popcount(input logic [MAX_W-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < MAX_W; i++) begin
            c = c + {4'b0000, v[i]};
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/param_alu_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : param_alu_seq_if                                          |
// | Purpose  : Issue handshake, operands and result/status bundle.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface param_alu_seq_if #(
    parameter int W = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     op;
    logic           sel_b_acc;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic [2*W-1:0] acc;
    logic           out_valid;
    logic           carry;
    logic           zero;
    logic           busy;

    modport master (
        output in_valid, op, sel_b_acc, in_a, in_b,
        input  in_ready, acc, out_valid, carry, zero, busy
    );

    modport slave (
        input  in_valid, op, sel_b_acc, in_a, in_b,
        output in_ready, acc, out_valid, carry, zero, busy
    );
endinterface
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seq_multiplier                                            |
// | Purpose  : W-step unsigned shift-add multiplier; done on last step.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module seq_multiplier #(
    parameter int W = 4
) (
    input  wire logic           clock,
    input  wire logic           resetn,
    input  wire logic           start,
    input  wire logic [W-1:0]   a,
    input  wire logic [W-1:0]   b,
    output logic                done,
    output logic [2*W-1:0]      product
);
    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [2*W-1:0] prod_q, prod_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           active_q, active_d;
    logic [2*W-1:0] prod_next;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        if (start) begin
            mcand_d  = {{W{1'b0}}, a};
            mplier_d = b;
            prod_d   = '0;
            cnt_d    = CW'(W);
            active_d = 1'b1;
        end else if (active_q) begin
            prod_d   = prod_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                active_d = 1'b0;
            end
        end
    end

    // The final step's partial sum is the product, so it is exposed combinationally.
    assign done    = active_q && (cnt_q == CW'(1));
    assign product = prod_next;

endmodule
`default_nettype wire

// File: rtl/param_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : param_alu_seq                                             |
// | Purpose  : W-bit ALU with 2W-bit accumulator, flags and seq. MUL.    |
// |            Define ALU_SAT_EN for saturating ADD/SUB.                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module param_alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W = 4
) (
    input  wire logic        clock,
    input  wire logic        resetn,
    param_alu_seq_if.slave   bus
);
    localparam int W2 = 2 * W;

    state_t          state_q, state_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic            carry_q, carry_d;
    logic            zero_q, zero_d;
    logic            out_valid_q, out_valid_d;

    logic [W-1:0]    op_a, op_b;
    logic [W:0]      sum_w, diff_w;
    logic            borrow;
    logic [W2-1:0]   res;
    logic            res_carry;
    logic            mul_start;
    logic            mul_done;
    logic [W2-1:0]   mul_product;

    assign op_a = bus.in_a;
    assign op_b = bus.sel_b_acc ? acc_q[W-1:0] : bus.in_b;

    seq_multiplier #(
        .W (W)
    ) u_mul (
        .clock   (clock),
        .resetn  (resetn),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        sum_w     = {1'b0, op_a} + {1'b0, op_b};
        diff_w    = {1'b0, op_a} - {1'b0, op_b};
        borrow    = (op_a < op_b);
        res       = acc_q;
        res_carry = carry_q;
        case (bus.op)
            OP_ADD: begin
`ifdef ALU_SAT_EN
                res = sum_w[W] ? {{W{1'b0}}, {W{1'b1}}} : W2'(sum_w);
`else
                res = W2'(sum_w);
`endif
                res_carry = sum_w[W];
            end
            OP_SUB: begin
`ifdef ALU_SAT_EN
                res = borrow ? '0 : W2'(diff_w);
`else
                res = W2'(diff_w);
`endif
                res_carry = borrow;
            end
            OP_LOGIC:    res = {~(op_a & op_b), ~(op_a ^ op_b)};
            OP_ORRED:    res = (|{op_a, op_b}) ? {{W{1'b0}}, {W{1'b1}}} : '0;
            OP_POPMATCH: res = ((popcount(MAX_W'(op_a)) == 5'd1) &&
                                (popcount(MAX_W'(op_b)) == 5'd2))
                               ? {{W{1'b1}}, {W{1'b0}}} : '0;
            OP_CONCAT:   res = {op_a, ~op_b};
            default:     res = acc_q;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;
        mul_start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.op == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = ST_MUL;
                    end else begin
                        out_valid_d = 1'b1;
                        // HOLD pulses out_valid but leaves acc and both flags alone.
                        if (bus.op != OP_HOLD) begin
                            acc_d  = res;
                            zero_d = (res == '0);
                        end
                        if ((bus.op == OP_ADD) || (bus.op == OP_SUB)) begin
                            carry_d = res_carry;
                        end
                    end
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    acc_d       = mul_product;
                    zero_d      = (mul_product == '0);
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.acc       = acc_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q == ST_MUL);
    assign bus.in_ready  = (state_q == ST_IDLE);

endmodule
`default_nettype wire
